// File: rtl/mc_main_control.sv
// Multicycle main control FSM for the RV32I core: datapath selects, write strobes and ALU op class.
// Optional MC_ILLEGAL_TRAP_EN: unknown opcodes park the FSM in TRAP and raise illegal_instr.
module mc_main_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TCNT_W      = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [1:0] alu_op,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] imm_src,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       instr_retired,
  output logic       mem_timeout
`ifdef MC_ILLEGAL_TRAP_EN
  ,
  output logic       illegal_instr
`endif
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_IA  = 7'b0010011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BEQ, JAL
`ifdef MC_ILLEGAL_TRAP_EN
    , TRAP
`endif
  } state_t;

  state_t            state_q, state_n;
  logic [TCNT_W-1:0] cnt_q, cnt_n;
  logic              wait_st, to_hit;

  assign wait_st = (state_q == FETCH) || (state_q == MEMREAD) || (state_q == MEMWRITE);
  // A ready memory in the same cycle the limit is reached completes normally.
  assign to_hit  = (MEM_TIMEOUT != 0) && wait_st && !mem_ready &&
                   (cnt_q == TCNT_W'(MEM_TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
    end
  end

  // Counter restarts on every state entry, including FETCH re-entry after an abort.
  always_comb begin
    cnt_n = cnt_q;
    if (state_n != state_q || to_hit)
      cnt_n = '0;
    else if (wait_st && !mem_ready)
      cnt_n = cnt_q + TCNT_W'(1);
  end

  always_comb begin
    state_n       = state_q;
    alu_op        = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    result_src    = 2'b00;
    imm_src       = 2'b00;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    mem_write     = 1'b0;
    instr_retired = 1'b0;
    mem_timeout   = to_hit;

    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase

    case (state_q)
      FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) state_n = DECODE;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LW, OP_SW: state_n = MEMADR;
          OP_R:         state_n = EXECR;
          OP_IA:        state_n = EXECI;
          OP_BEQ:       state_n = BEQ;
          OP_JAL:       state_n = JAL;
`ifdef MC_ILLEGAL_TRAP_EN
          default:      state_n = TRAP;
`else
          default:      state_n = FETCH;
`endif
        endcase
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_n   = (op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready)   state_n = MEMWB;
        else if (to_hit) state_n = FETCH;
      end
      MEMWB: begin
        result_src    = 2'b01;
        reg_write     = 1'b1;
        instr_retired = 1'b1;
        state_n       = FETCH;
      end
      MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = !to_hit;
        if (mem_ready) begin
          instr_retired = 1'b1;
          state_n       = FETCH;
        end else if (to_hit) begin
          state_n = FETCH;
        end
      end
      EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_n   = ALUWB;
      end
      EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_n   = ALUWB;
      end
      ALUWB: begin
        reg_write     = 1'b1;
        instr_retired = 1'b1;
        state_n       = FETCH;
      end
      BEQ: begin
        alu_src_a     = 2'b10;
        alu_op        = 2'b01;
        pc_write      = zero;
        instr_retired = 1'b1;
        state_n       = FETCH;
      end
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_n   = ALUWB;
      end
`ifdef MC_ILLEGAL_TRAP_EN
      TRAP: state_n = TRAP;
`endif
      default: state_n = FETCH;
    endcase

    // Reset is asynchronous on the outputs as well, not just on the state register.
    if (!rst_n) begin
      alu_op        = 2'b00;
      alu_src_a     = 2'b00;
      alu_src_b     = 2'b00;
      result_src    = 2'b00;
      imm_src       = 2'b00;
      adr_src       = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      reg_write     = 1'b0;
      mem_write     = 1'b0;
      instr_retired = 1'b0;
      mem_timeout   = 1'b0;
    end
  end

`ifdef MC_ILLEGAL_TRAP_EN
  assign illegal_instr = rst_n && (state_q == TRAP);
`endif

endmodule

// File: tb/tb_mc_main_control.sv
// Directed-vector bench for mc_main_control; per-cycle output signatures checked against hand-derived values.
module tb_mc_main_control;
  logic       clk, rst_n, zero, mem_ready;
  logic [6:0] op;
  logic [1:0] alu_op, alu_src_a, alu_src_b, result_src, imm_src;
  logic       adr_src, ir_write, pc_write, reg_write, mem_write, instr_retired, mem_timeout;
`ifdef MC_ILLEGAL_TRAP_EN
  logic       illegal_instr;
`endif
  int n_chk, n_fail;

  mc_main_control #(.MEM_TIMEOUT(16), .TCNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .imm_src(imm_src), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .mem_write(mem_write), .instr_retired(instr_retired), .mem_timeout(mem_timeout)
`ifdef MC_ILLEGAL_TRAP_EN
    , .illegal_instr(illegal_instr)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [16:0] sig;
  assign sig = {alu_op, alu_src_a, alu_src_b, result_src, imm_src, adr_src,
                ir_write, pc_write, reg_write, mem_write, instr_retired, mem_timeout};

  function automatic logic [16:0] mk(input logic [1:0] ao, a, b, rs, im,
                                     input logic adr, ir, pc, rw, mw, ret, to);
    return {ao, a, b, rs, im, adr, ir, pc, rw, mw, ret, to};
  endfunction

  // Leaves the bench at a falling edge with the FSM freshly in FETCH.
  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    op = 7'b0000011; mem_ready = 1'b1; zero = 1'b0; rst_n = 1'b0;
    @(negedge clk); #1;
    n_chk++;
    if (sig !== 17'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want %h", sig, 17'h0);
    end
`ifdef MC_ILLEGAL_TRAP_EN
    n_chk++;
    if (illegal_instr !== 1'b0) begin
      n_fail++; $display("FAIL reset_illegal: got %b want 0", illegal_instr);
    end
`endif
  endtask

  task automatic test_lw();
    logic [16:0] e[$];
    e = '{mk(0,0,2,2,0,0,1,1,0,0,0,0), mk(0,1,1,0,0,0,0,0,0,0,0,0),
          mk(0,2,1,0,0,0,0,0,0,0,0,0), mk(0,0,0,0,0,1,0,0,0,0,0,0),
          mk(0,0,0,1,0,0,0,0,1,0,1,0), mk(0,0,2,2,0,0,1,1,0,0,0,0)};
    op = 7'b0000011; mem_ready = 1'b1;
    do_reset();
    for (int i = 0; i < e.size(); i++) begin
      #1; n_chk++;
      if (sig !== e[i]) begin
        n_fail++; $display("FAIL lw cyc%0d: got %h want %h", i, sig, e[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_beq();
    logic [16:0] e[$];
    logic        z[$];
    e = '{mk(0,0,2,2,2,0,1,1,0,0,0,0), mk(0,1,1,0,2,0,0,0,0,0,0,0),
          mk(1,2,0,0,2,0,0,1,0,0,1,0),
          mk(0,0,2,2,2,0,1,1,0,0,0,0), mk(0,1,1,0,2,0,0,0,0,0,0,0),
          mk(1,2,0,0,2,0,0,0,0,0,1,0),
          mk(0,0,2,2,2,0,1,1,0,0,0,0)};
    z = '{1, 1, 1, 0, 0, 0, 0};
    op = 7'b1100011; mem_ready = 1'b1;
    do_reset();
    for (int i = 0; i < e.size(); i++) begin
      zero = z[i]; #1; n_chk++;
      if (sig !== e[i]) begin
        n_fail++; $display("FAIL beq cyc%0d: got %h want %h", i, sig, e[i]);
      end
      @(negedge clk);
    end
    zero = 1'b0;
  endtask

  task automatic test_sw_wait();
    logic [16:0] e[$];
    logic        m[$];
    e = '{mk(0,0,2,2,1,0,1,1,0,0,0,0), mk(0,1,1,0,1,0,0,0,0,0,0,0),
          mk(0,2,1,0,1,0,0,0,0,0,0,0), mk(0,0,0,0,1,1,0,0,0,1,0,0),
          mk(0,0,0,0,1,1,0,0,0,1,0,0), mk(0,0,0,0,1,1,0,0,0,1,0,0),
          mk(0,0,0,0,1,1,0,0,0,1,1,0), mk(0,0,2,2,1,0,1,1,0,0,0,0)};
    m = '{1, 1, 1, 0, 0, 0, 1, 1};
    op = 7'b0100011;
    do_reset();
    for (int i = 0; i < e.size(); i++) begin
      mem_ready = m[i]; #1; n_chk++;
      if (sig !== e[i]) begin
        n_fail++; $display("FAIL sw_wait cyc%0d: got %h want %h", i, sig, e[i]);
      end
      @(negedge clk);
    end
  endtask

  // R-type, I-ALU and jal issued back to back without intervening reset.
  task automatic test_back_to_back();
    logic [16:0] e[$];
    logic [6:0]  o[$];
    e = '{mk(0,0,2,2,0,0,1,1,0,0,0,0), mk(0,1,1,0,0,0,0,0,0,0,0,0),
          mk(2,2,0,0,0,0,0,0,0,0,0,0), mk(0,0,0,0,0,0,0,0,1,0,1,0),
          mk(0,0,2,2,0,0,1,1,0,0,0,0), mk(0,1,1,0,0,0,0,0,0,0,0,0),
          mk(2,2,1,0,0,0,0,0,0,0,0,0), mk(0,0,0,0,0,0,0,0,1,0,1,0),
          mk(0,0,2,2,3,0,1,1,0,0,0,0), mk(0,1,1,0,3,0,0,0,0,0,0,0),
          mk(0,1,2,0,3,0,0,1,0,0,0,0), mk(0,0,0,0,3,0,0,0,1,0,1,0)};
    o = '{7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011,
          7'b0010011, 7'b0010011, 7'b0010011, 7'b0010011,
          7'b1101111, 7'b1101111, 7'b1101111, 7'b1101111};
    mem_ready = 1'b1;
    op = o[0];
    do_reset();
    for (int i = 0; i < e.size(); i++) begin
      op = o[i]; #1; n_chk++;
      if (sig !== e[i]) begin
        n_fail++; $display("FAIL back_to_back cyc%0d: got %h want %h", i, sig, e[i]);
      end
      @(negedge clk);
    end
  endtask

  // lw with mem_ready low in MEMREAD: aborts when 16 waits have accumulated.
  task automatic test_timeout_memread();
    logic [16:0] e[$];
    logic        m[$];
    e = '{mk(0,0,2,2,0,0,1,1,0,0,0,0), mk(0,1,1,0,0,0,0,0,0,0,0,0),
          mk(0,2,1,0,0,0,0,0,0,0,0,0)};
    m = '{1, 1, 1};
    for (int i = 0; i < 16; i++) begin
      e.push_back(mk(0,0,0,0,0,1,0,0,0,0,0,0)); m.push_back(1'b0);
    end
    e.push_back(mk(0,0,0,0,0,1,0,0,0,0,0,1)); m.push_back(1'b0);
    e.push_back(mk(0,0,2,2,0,0,0,0,0,0,0,0)); m.push_back(1'b0);
    e.push_back(mk(0,0,2,2,0,0,1,1,0,0,0,0)); m.push_back(1'b1);
    op = 7'b0000011;
    do_reset();
    for (int i = 0; i < e.size(); i++) begin
      mem_ready = m[i]; #1; n_chk++;
      if (sig !== e[i]) begin
        n_fail++; $display("FAIL timeout_memread cyc%0d: got %h want %h", i, sig, e[i]);
      end
      @(negedge clk);
    end
  endtask

  // mem_ready arriving exactly at the limit completes the load normally.
  task automatic test_ready_at_limit();
    logic [16:0] e[$];
    logic        m[$];
    e = '{mk(0,0,2,2,0,0,1,1,0,0,0,0), mk(0,1,1,0,0,0,0,0,0,0,0,0),
          mk(0,2,1,0,0,0,0,0,0,0,0,0)};
    m = '{1, 1, 1};
    for (int i = 0; i < 16; i++) begin
      e.push_back(mk(0,0,0,0,0,1,0,0,0,0,0,0)); m.push_back(1'b0);
    end
    e.push_back(mk(0,0,0,0,0,1,0,0,0,0,0,0)); m.push_back(1'b1);
    e.push_back(mk(0,0,0,1,0,0,0,0,1,0,1,0)); m.push_back(1'b1);
    op = 7'b0000011;
    do_reset();
    for (int i = 0; i < e.size(); i++) begin
      mem_ready = m[i]; #1; n_chk++;
      if (sig !== e[i]) begin
        n_fail++; $display("FAIL ready_at_limit cyc%0d: got %h want %h", i, sig, e[i]);
      end
      @(negedge clk);
    end
  endtask

  // Fetch timeout re-enters FETCH with a cleared counter.
  task automatic test_timeout_fetch();
    logic [16:0] e[$];
    logic        m[$];
    for (int i = 0; i < 16; i++) begin
      e.push_back(mk(0,0,2,2,0,0,0,0,0,0,0,0)); m.push_back(1'b0);
    end
    e.push_back(mk(0,0,2,2,0,0,0,0,0,0,0,1)); m.push_back(1'b0);
    for (int i = 0; i < 3; i++) begin
      e.push_back(mk(0,0,2,2,0,0,0,0,0,0,0,0)); m.push_back(1'b0);
    end
    e.push_back(mk(0,0,2,2,0,0,1,1,0,0,0,0)); m.push_back(1'b1);
    e.push_back(mk(0,1,1,0,0,0,0,0,0,0,0,0)); m.push_back(1'b1);
    op = 7'b0110011; mem_ready = 1'b0;
    do_reset();
    for (int i = 0; i < e.size(); i++) begin
      mem_ready = m[i]; #1; n_chk++;
      if (sig !== e[i]) begin
        n_fail++; $display("FAIL timeout_fetch cyc%0d: got %h want %h", i, sig, e[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    op = 7'b0110011; mem_ready = 1'b1;
    do_reset();
    @(negedge clk);
    @(negedge clk);
    #1; n_chk++;
    if (sig !== mk(2,2,0,0,0,0,0,0,0,0,0,0)) begin
      n_fail++; $display("FAIL async_execr: got %h want %h", sig, mk(2,2,0,0,0,0,0,0,0,0,0,0));
    end
    #1 rst_n = 1'b0;
    #1; n_chk++;
    if (sig !== 17'h0) begin
      n_fail++; $display("FAIL async_reset_now: got %h want %h", sig, 17'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1; n_chk++;
    if (sig !== mk(0,0,2,2,0,0,1,1,0,0,0,0)) begin
      n_fail++; $display("FAIL async_release_fetch: got %h want %h", sig, mk(0,0,2,2,0,0,1,1,0,0,0,0));
    end
    @(negedge clk); #1; n_chk++;
    if (sig !== mk(0,1,1,0,0,0,0,0,0,0,0,0)) begin
      n_fail++; $display("FAIL async_release_decode: got %h want %h", sig, mk(0,1,1,0,0,0,0,0,0,0,0,0));
    end
  endtask

  task automatic test_illegal();
    op = 7'b1111111; mem_ready = 1'b1;
    do_reset();
    #1; n_chk++;
    if (sig !== mk(0,0,2,2,0,0,1,1,0,0,0,0)) begin
      n_fail++; $display("FAIL illegal_fetch: got %h want %h", sig, mk(0,0,2,2,0,0,1,1,0,0,0,0));
    end
    @(negedge clk); #1; n_chk++;
    if (sig !== mk(0,1,1,0,0,0,0,0,0,0,0,0)) begin
      n_fail++; $display("FAIL illegal_decode: got %h want %h", sig, mk(0,1,1,0,0,0,0,0,0,0,0,0));
    end
`ifdef MC_ILLEGAL_TRAP_EN
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1; n_chk++;
      if (sig !== 17'h0 || illegal_instr !== 1'b1) begin
        n_fail++; $display("FAIL trap cyc%0d: got %h/%b want %h/1", i, sig, illegal_instr, 17'h0);
      end
    end
`else
    @(negedge clk); #1; n_chk++;
    if (sig !== mk(0,0,2,2,0,0,1,1,0,0,0,0)) begin
      n_fail++; $display("FAIL illegal_nop_fetch: got %h want %h", sig, mk(0,0,2,2,0,0,1,1,0,0,0,0));
    end
`endif
    @(negedge clk);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; op = '0; zero = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_lw();
    test_beq();
    test_sw_wait();
    test_back_to_back();
    test_timeout_memread();
    test_ready_at_limit();
    test_timeout_fetch();
    test_async_reset();
    test_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_main_control.md
Name: mc_main_control

Overview:
- Multicycle main control FSM for the RV32I core.
- Sits directly upstream of the ALU decoder: produces `alu_op[1:0]` for it, plus every datapath mux select and write strobe.
- Sequences fetch, decode, execute, memory and writeback over multiple cycles.
- Stalls on a memory-ready handshake, with a bounded wait timeout.

Parameters:
- MEM_TIMEOUT, 16: max consecutive cycles a memory state waits for `mem_ready` before abort; 0 disables the timeout.
- TCNT_W, 5: width of the wait counter; must satisfy 2^TCNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- op  in  7  opcode field of the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- alu_op  out  2  to ALU decoder: 00 add, 01 sub, 10 funct-decoded
- alu_src_a  out  2  00 PC, 01 OldPC, 10 RD1
- alu_src_b  out  2  00 RD2, 01 ImmExt, 10 constant 4
- result_src  out  2  00 ALUOut, 01 Data, 10 ALUResult
- imm_src  out  2  00 I-type, 01 S-type, 10 B-type, 11 J-type
- adr_src  out  1  0 PC, 1 Result
- ir_write  out  1  instruction register load
- pc_write  out  1  PC load
- reg_write  out  1  register file write
- mem_write  out  1  data memory write
- instr_retired  out  1  one-cycle pulse per completed instruction
- mem_timeout  out  1  one-cycle pulse on memory wait abort

Behaviour:
- Reset:
  - Asynchronous: `rst_n` low forces state FETCH and clears the wait counter immediately, mid-instruction included.
  - While in reset, all strobes (`ir_write`, `pc_write`, `reg_write`, `mem_write`, `instr_retired`, `mem_timeout`) are 0 and all selects are 00/0.
- Output style: Moore outputs decoded from state, except the strobes gated by `mem_ready` and `zero` as stated below.
- `imm_src` is combinational from `op`:
  - lw and I-ALU (0000011, 0010011): 00
  - sw (0100011): 01
  - beq (1100011): 10
  - jal (1101111): 11
  - anything else: 00
- State outputs (unlisted outputs are 0):
  - FETCH: adr_src=0, a=00, b=10, alu_op=00, result_src=10. `ir_write` and `pc_write` are asserted only while `mem_ready`=1. Stays in FETCH until `mem_ready`, then goes to DECODE.
  - DECODE: a=01, b=01, alu_op=00 (branch target precompute).
    - lw/sw → MEMADR
    - R-type (0110011) → EXECR
    - I-ALU → EXECI
    - beq → BEQ
    - jal → JAL
    - any other opcode → FETCH (treated as NOP, no retire)
  - MEMADR: a=10, b=01, alu_op=00. lw → MEMREAD, sw → MEMWRITE.
  - MEMREAD: adr_src=1, result_src=00. Waits for `mem_ready`, then → MEMWB.
  - MEMWB: result_src=01, reg_write=1. → FETCH with retire.
  - MEMWRITE: adr_src=1, result_src=00. `mem_write` is held asserted while waiting. → FETCH with retire on `mem_ready`.
  - EXECR: a=10, b=00, alu_op=10. → ALUWB.
  - EXECI: a=10, b=01, alu_op=10. → ALUWB.
  - ALUWB: result_src=00, reg_write=1. → FETCH with retire.
  - BEQ: a=10, b=00, alu_op=01, result_src=00, pc_write=zero. → FETCH with retire.
  - JAL: a=01, b=10, alu_op=00, result_src=00, pc_write=1. → ALUWB.
- Latencies with `mem_ready` always 1:
  - lw: 5 cycles
  - sw, R-type, I-ALU, jal: 4 cycles
  - beq: 3 cycles
- `instr_retired` pulses in the last cycle of the instruction (the transition cycle into FETCH).
- Wait counter (FETCH, MEMREAD, MEMWRITE):
  - Clears on state entry.
  - Increments each cycle `mem_ready`=0.
  - When it equals MEM_TIMEOUT with `mem_ready` still 0: `mem_timeout` pulses, all write strobes are forced 0 that cycle, and the next state is FETCH with no retire.
  - `mem_ready`=1 in the same cycle the count is reached wins over the timeout (normal completion).
- The timeout in FETCH re-enters FETCH; the counter clears.

Optional Feature:
- Macro: MC_ILLEGAL_TRAP_EN.
- Defined:
  - An unrecognised opcode in DECODE goes to state TRAP.
  - TRAP holds all strobes 0 and never exits except on reset.
  - Adds output `illegal_instr` (1 bit), high while in TRAP, 0 at reset.
- Not defined: an unknown opcode returns to FETCH as a NOP, and neither the TRAP state nor the `illegal_instr` port exists.

Test Plan:
- Reset, then `rst_n` high, `mem_ready`=1, op=0000011 → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; `reg_write` only in cycle 5 with result_src=01; `instr_retired` pulses in cycle 5.
- op=1100011 with zero=1, then again with zero=0 → `pc_write` high in the BEQ cycle only when zero=1; alu_op=01 in BEQ; 3 cycles each.
- op=0100011, `mem_ready` held 0 for 3 cycles in MEMWRITE → `mem_write` high 4 cycles; retire on the 4th.
- `mem_ready`=0 for 16 cycles in MEMREAD (MEM_TIMEOUT=16) → `mem_timeout` pulses once, no `reg_write`, back in FETCH.
- `rst_n` asserted low while in EXECR → outputs go to reset values immediately, without waiting for a clock edge; state is FETCH on release.
- op=1111111 → with MC_ILLEGAL_TRAP_EN, `illegal_instr`=1 and the FSM stays in TRAP for 20 cycles; without the macro, the FSM returns to FETCH after DECODE with no retire.
